// File: rtl/fpaddsub_rr_sched_32.sv
// Round-robin scheduler sharing one FP add/sub unit among NREQ requesters.
// Issues at most one operation per cycle and routes each result back to its owner.
module fpaddsub_rr_sched_32 #(
    parameter int NREQ   = 4,
    parameter int FU_LAT = 0,
    parameter int IDW    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_en,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    input  logic [NREQ-1:0]      req_op,
    output logic [31:0]          fu_a,
    output logic [31:0]          fu_b,
    output logic                 fu_op,
    output logic                 fu_valid,
    input  logic [31:0]          fu_result,
    input  logic [4:0]           fu_flags,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_result,
    output logic [4:0]           rsp_flags,
    output logic [3:0]           inflight
);

    localparam int NS = FU_LAT + 1;

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            grant_found;
    logic [IDW-1:0]  grant_id;
    logic [IDW:0]    cand;
    logic            hs;

    logic [31:0]     fu_a_q, fu_a_d, fu_b_q, fu_b_d;
    logic            fu_op_q, fu_op_d, fu_valid_q;

    logic            pv_q  [NS];
    logic [IDW-1:0]  pid_q [NS];

    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [31:0]     rsp_result_q, rsp_result_d;
    logic [4:0]      rsp_flags_q, rsp_flags_d;
    logic [3:0]      inflight_q, inflight_d;

    // Search from ptr upward with wrap; the first pending request wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        req_ready   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (issue_en && !grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[IDW-1:0];
            end
        end
        if (grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign hs = grant_found;

    always_comb begin
        ptr_d   = ptr_q;
        fu_a_d  = fu_a_q;
        fu_b_d  = fu_b_q;
        fu_op_d = fu_op_q;
        if (hs) begin
            ptr_d   = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
            fu_a_d  = req_a[32*grant_id +: 32];
            fu_b_d  = req_b[32*grant_id +: 32];
            fu_op_d = req_op[grant_id];
        end
    end

    // The last tracking stage lines up with the unit output for its operation.
    always_comb begin
        rsp_valid_d  = '0;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        if (pv_q[NS-1]) begin
            rsp_valid_d[pid_q[NS-1]] = 1'b1;
            rsp_id_d                 = pid_q[NS-1];
            rsp_result_d             = fu_result;
            rsp_flags_d              = fu_flags;
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({hs, |rsp_valid_q})
            2'b10:   inflight_d = inflight_q + 4'd1;
            2'b01:   inflight_d = inflight_q - 4'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q        <= '0;
            fu_a_q       <= '0;
            fu_b_q       <= '0;
            fu_op_q      <= 1'b0;
            fu_valid_q   <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            inflight_q   <= '0;
            for (int s = 0; s < NS; s++) begin
                pv_q[s]  <= 1'b0;
                pid_q[s] <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            fu_a_q       <= fu_a_d;
            fu_b_q       <= fu_b_d;
            fu_op_q      <= fu_op_d;
            fu_valid_q   <= hs;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            inflight_q   <= inflight_d;
            pv_q[0]      <= hs;
            pid_q[0]     <= grant_id;
            for (int s = 1; s < NS; s++) begin
                pv_q[s]  <= pv_q[s-1];
                pid_q[s] <= pid_q[s-1];
            end
        end
    end

    assign fu_a       = fu_a_q;
    assign fu_b       = fu_b_q;
    assign fu_op      = fu_op_q;
    assign fu_valid   = fu_valid_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign inflight   = inflight_q;

endmodule

// File: tb/tb_fpaddsub_rr_sched_32.sv
// Bench for fpaddsub_rr_sched_32: two instances (unit latency 0 and 3) share one
// stimulus stream; a behavioural FP unit feeds each, and a scoreboard tracks responses.
module tb_fpaddsub_rr_sched_32;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int ND   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic                issue_en;
    logic [NREQ-1:0]     req_valid;
    logic [32*NREQ-1:0]  req_a, req_b;
    logic [NREQ-1:0]     req_op;

    logic [NREQ-1:0] req_ready  [ND];
    logic [31:0]     fu_a       [ND];
    logic [31:0]     fu_b       [ND];
    logic            fu_op      [ND];
    logic            fu_valid   [ND];
    logic [31:0]     fu_result  [ND];
    logic [4:0]      fu_flags   [ND];
    logic [NREQ-1:0] rsp_valid  [ND];
    logic [IDW-1:0]  rsp_id     [ND];
    logic [31:0]     rsp_result [ND];
    logic [4:0]      rsp_flags  [ND];
    logic [3:0]      inflight   [ND];

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // Single -> double widening for normal numbers; zero/denormal treated as zero.
    function automatic real s2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        d = {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Returns {flags, result}; truncates back to single and raises NX on lost bits.
    function automatic logic [36:0] fp_op(input logic [31:0] a, input logic [31:0] b, input logic op);
        real         r;
        logic [63:0] d;
        logic [31:0] res;
        logic        nx;
        r = op ? (s2r(a) - s2r(b)) : (s2r(a) + s2r(b));
        if (r == 0.0) return 37'd0;
        d   = $realtobits(r);
        res = {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
        nx  = |d[28:0];
        return {4'b0000, nx, res};
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < ND; gi++) begin : g_dut
            localparam int L = (gi == 0) ? 0 : 3;
            logic [36:0] fx;
            assign fx = fp_op(fu_a[gi], fu_b[gi], fu_op[gi]);

            fpaddsub_rr_sched_32 #(.NREQ(NREQ), .FU_LAT(L), .IDW(IDW)) dut (
                .clk        (clk),
                .rst        (rst_n),
                .issue_en   (issue_en),
                .req_valid  (req_valid),
                .req_ready  (req_ready[gi]),
                .req_a      (req_a),
                .req_b      (req_b),
                .req_op     (req_op),
                .fu_a       (fu_a[gi]),
                .fu_b       (fu_b[gi]),
                .fu_op      (fu_op[gi]),
                .fu_valid   (fu_valid[gi]),
                .fu_result  (fu_result[gi]),
                .fu_flags   (fu_flags[gi]),
                .rsp_valid  (rsp_valid[gi]),
                .rsp_id     (rsp_id[gi]),
                .rsp_result (rsp_result[gi]),
                .rsp_flags  (rsp_flags[gi]),
                .inflight   (inflight[gi])
            );

            // Garbage outside valid windows so a mistimed sample is visible.
            if (L == 0) begin : g_comb
                assign fu_result[gi] = fu_valid[gi] ? fx[31:0]  : 32'hDEADBEEF;
                assign fu_flags[gi]  = fu_valid[gi] ? fx[36:32] : 5'h1F;
            end else begin : g_pipe
                logic [36:0] pd  [L];
                logic        pvl [L];
                always @(posedge clk) begin
                    pd[0]  <= fx;
                    pvl[0] <= fu_valid[gi];
                    for (int k = 1; k < L; k++) begin
                        pd[k]  <= pd[k-1];
                        pvl[k] <= pvl[k-1];
                    end
                end
                assign fu_result[gi] = pvl[L-1] ? pd[L-1][31:0]  : 32'hDEADBEEF;
                assign fu_flags[gi]  = pvl[L-1] ? pd[L-1][36:32] : 5'h1F;
            end
        end
    endgenerate

    typedef struct {
        int          id;
        logic [31:0] res;
        logic [4:0]  flg;
        int          due;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          ptr_m   = 0;
    bit          rnd_mode = 1'b0;
    logic [31:0] vals [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                              32'h3F000000, 32'h40800000, 32'hBF800000};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic op);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[i]         = op;
    endtask

    task automatic rand_op(input int i);
        set_op(i, vals[$urandom_range(0, 5)], vals[$urandom_range(0, 5)], 1'($urandom_range(0, 1)));
    endtask

    task automatic check_out(input int d);
        exp_t e;
        bit   have;
        int   qs;
        qs   = (d == 0) ? sb0.size() : sb1.size();
        have = 1'b0;
        if (d == 0 && sb0.size() > 0 && sb0[0].due <= cyc) begin
            e = sb0.pop_front(); have = 1'b1;
        end
        if (d == 1 && sb1.size() > 0 && sb1[0].due <= cyc) begin
            e = sb1.pop_front(); have = 1'b1;
        end
        chk($sformatf("inflight[%0d] c%0d", d, cyc), 64'(inflight[d]), 64'(qs));
        if (have) begin
            $display("[TB] c%0d dut%0d rsp id=%0d result=%h flags=%b", cyc, d, e.id, e.res, e.flg);
            chk($sformatf("rsp_due[%0d] c%0d", d, cyc), 64'(cyc), 64'(e.due));
            chk($sformatf("rsp_valid[%0d] c%0d", d, cyc), 64'(rsp_valid[d]), 64'(1 << e.id));
            chk($sformatf("rsp_id[%0d] c%0d", d, cyc), 64'(rsp_id[d]), 64'(e.id));
            chk($sformatf("rsp_result[%0d] c%0d", d, cyc), 64'(rsp_result[d]), 64'(e.res));
            chk($sformatf("rsp_flags[%0d] c%0d", d, cyc), 64'(rsp_flags[d]), 64'(e.flg));
        end else begin
            chk($sformatf("rsp_idle[%0d] c%0d", d, cyc), 64'(rsp_valid[d]), 64'd0);
        end
    endtask

    task automatic step(input logic [NREQ-1:0] v, input logic en);
        int          w;
        logic [36:0] r;
        exp_t        e;
        logic [31:0] efa, efb;
        logic        efop;
        req_valid = v;
        issue_en  = en;
        #1;
        w = -1;
        if (en) begin
            for (int k = 0; k < NREQ; k++) begin
                if (w < 0 && v[(ptr_m + k) % NREQ]) w = (ptr_m + k) % NREQ;
            end
        end
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("req_ready[%0d] c%0d", d, cyc), 64'(req_ready[d]), (w < 0) ? 64'd0 : 64'(1 << w));
        end
        efa = 32'd0; efb = 32'd0; efop = 1'b0;
        if (w >= 0) begin
            efa  = req_a[32*w +: 32];
            efb  = req_b[32*w +: 32];
            efop = req_op[w];
            r    = fp_op(efa, efb, efop);
            e.id = w; e.res = r[31:0]; e.flg = r[36:32];
            e.due = cyc + 2 + lat_of(0); sb0.push_back(e);
            e.due = cyc + 2 + lat_of(1); sb1.push_back(e);
            ptr_m = (w + 1) % NREQ;
            $display("[TB] c%0d grant req%0d a=%h b=%h op=%0d", cyc, w, efa, efb, efop);
        end
        @(posedge clk); #1;
        cyc++;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("fu_valid[%0d] c%0d", d, cyc), 64'(fu_valid[d]), (w >= 0) ? 64'd1 : 64'd0);
            if (w >= 0) begin
                chk($sformatf("fu_a[%0d] c%0d", d, cyc), 64'(fu_a[d]), 64'(efa));
                chk($sformatf("fu_b[%0d] c%0d", d, cyc), 64'(fu_b[d]), 64'(efb));
                chk($sformatf("fu_op[%0d] c%0d", d, cyc), 64'(fu_op[d]), 64'(efop));
            end
            check_out(d);
        end
        if (rnd_mode && w >= 0) rand_op(w);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b1);
    endtask

    task automatic chk_zero(input string tag);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("%s fu_a[%0d]", tag, d), 64'(fu_a[d]), 64'd0);
            chk($sformatf("%s fu_b[%0d]", tag, d), 64'(fu_b[d]), 64'd0);
            chk($sformatf("%s fu_op[%0d]", tag, d), 64'(fu_op[d]), 64'd0);
            chk($sformatf("%s fu_valid[%0d]", tag, d), 64'(fu_valid[d]), 64'd0);
            chk($sformatf("%s rsp_valid[%0d]", tag, d), 64'(rsp_valid[d]), 64'd0);
            chk($sformatf("%s rsp_id[%0d]", tag, d), 64'(rsp_id[d]), 64'd0);
            chk($sformatf("%s rsp_result[%0d]", tag, d), 64'(rsp_result[d]), 64'd0);
            chk($sformatf("%s rsp_flags[%0d]", tag, d), 64'(rsp_flags[d]), 64'd0);
            chk($sformatf("%s inflight[%0d]", tag, d), 64'(inflight[d]), 64'd0);
        end
    endtask

    // Asserts reset right now, checks outputs cleared immediately, releases after two edges.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk_zero(tag);
        sb0.delete();
        sb1.delete();
        ptr_m = 0;
        repeat (2) begin
            @(posedge clk); #1; cyc++;
        end
        chk_zero({tag, "_held"});
        rst_n = 1'b1;
        $display("[TB] c%0d reset released (%s)", cyc, tag);
    endtask

    initial begin
        rst_n     = 1'b1;
        issue_en  = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        #2;
        do_reset("por");

        // Single add on req0.
        set_op(0, 32'h3F800000, 32'h40000000, 1'b0);
        step(4'b0001, 1'b1);
        step(4'b0000, 1'b1);
        chk("t1_rsp_valid", 64'(rsp_valid[0]), 64'h1);
        chk("t1_rsp_result", 64'(rsp_result[0]), 64'h40400000);
        chk("t1_rsp_flags", 64'(rsp_flags[0]), 64'h0);
        idle(5);

        // Subtract on req2; the latency-3 instance answers 5 cycles after handshake.
        set_op(2, 32'h40400000, 32'h3F800000, 1'b1);
        step(4'b0100, 1'b1);
        idle(4);
        chk("t2_rsp_valid", 64'(rsp_valid[1]), 64'h4);
        chk("t2_rsp_result", 64'(rsp_result[1]), 64'h40000000);
        idle(2);

        // Fairness: pointer now sits at 3.
        set_op(0, 32'h40800000, 32'h3F000000, 1'b0);
        req_valid = 4'b0101; issue_en = 1'b1; #1;
        chk("t4_first", 64'(req_ready[0]), 64'h1);
        step(4'b0101, 1'b1);
        chk("t4_second", 64'(req_ready[0]), 64'h4);
        step(4'b0101, 1'b1);
        idle(6);

        // Inexact add propagates the flag.
        set_op(1, 32'h3F800000, 32'h30800000, 1'b0);
        step(4'b0010, 1'b1);
        idle(4);
        chk("nx_result", 64'(rsp_result[1]), 64'h3F800000);
        chk("nx_flags", 64'(rsp_flags[1]), 64'h01);
        idle(2);

        // All four requesters continuously from reset.
        do_reset("t3");
        for (int i = 0; i < NREQ; i++) rand_op(i);
        rnd_mode = 1'b1;
        for (int i = 0; i < 12; i++) step(4'b1111, 1'b1);
        chk("t3_inflight0", 64'(inflight[0]), 64'd2);
        chk("t3_inflight1", 64'(inflight[1]), 64'd5);

        // issue_en gap mid-stream.
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b0);
        chk("t5_drain0", 64'(inflight[0]), 64'd0);
        req_valid = 4'b1111; issue_en = 1'b1; #1;
        chk("t5_resume", 64'(req_ready[0]), 64'h1);
        step(4'b1111, 1'b1);
        idle(6);
        chk("t5_drain0_end", 64'(inflight[0]), 64'd0);
        chk("t5_drain1_end", 64'(inflight[1]), 64'd0);

        // Reset one cycle after three back-to-back handshakes.
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b1);
        do_reset("t6");
        idle(8);
        req_valid = 4'b1111; issue_en = 1'b1; #1;
        chk("t6_first_grant", 64'(req_ready[0]), 64'h1);
        step(4'b1111, 1'b1);
        rnd_mode = 1'b0;
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
